// File: rtl/rtc_write_ctrl_if.sv
// Time-set request bus between the user logic (master) and the RTC write controller (slave).
interface rtc_write_ctrl_if;
  logic       start;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output sec_bcd,
    output min_bcd,
    output hour_bcd,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  sec_bcd,
    input  min_bcd,
    input  hour_bcd,
    output busy,
    output done
  );
endinterface

// File: rtl/rtc_write_ctrl.sv
// 3-wire RTC write controller: one start writes seconds, minutes and hours as 16-bit frames.
// Define RTC_WP_SEQ_EN to wrap the sequence in write-protect clear (first) and set (last) frames.
module rtc_write_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned T_CE    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rtc_write_ctrl_if.slave ctrl,
  output logic            CE,
  output logic            SCK,
  inout  wire             IO
);

  typedef enum logic [2:0] {
    StIdle,
    StCeSetup,
    StShift,
    StCeHold,
    StGap,
    StDone
  } state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] TceLast = 8'(T_CE - 1);

`ifdef RTC_WP_SEQ_EN
  localparam logic [2:0] FirstFrame = 3'd0;
  localparam logic [2:0] LastFrame  = 3'd4;
`else
  localparam logic [2:0] FirstFrame = 3'd1;
  localparam logic [2:0] LastFrame  = 3'd3;
`endif

  // Frame word is {data, command}; bit 0 is shifted out first.
  function automatic logic [15:0] frame_word(input logic [2:0] idx, input logic [6:0] s,
                                             input logic [6:0] m, input logic [6:0] h);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {8'h00, 8'h8E};
      3'd1:    w = {1'b0, s, 8'h80};
      3'd2:    w = {1'b0, m, 8'h82};
      3'd3:    w = {1'b0, h, 8'h84};
      3'd4:    w = {8'h80, 8'h8E};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [2:0]  frame_q;
  logic [6:0]  sec_q, min_q, hour_q;
  logic        ce_q, sck_q, io_q, io_oe_q;
  logic        busy_q, done_q;

  logic [15:0] cur_word, nxt_word, start_word;
  logic [3:0]  bit_nxt;
  logic        unused_bcd_msbs;

  assign cur_word   = frame_word(frame_q, sec_q, min_q, hour_q);
  assign nxt_word   = frame_word(frame_q + 3'd1, sec_q, min_q, hour_q);
  assign start_word = frame_word(FirstFrame, ctrl.sec_bcd[6:0], ctrl.min_bcd[6:0],
                                 ctrl.hour_bcd[6:0]);
  assign bit_nxt    = bit_q + 4'd1;

  // Bit 7 of every time register is forced to 0 (CH=0, 24-hour mode).
  assign unused_bcd_msbs = ^{ctrl.sec_bcd[7], ctrl.min_bcd[7], ctrl.hour_bcd[7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      frame_q <= 3'd0;
      sec_q   <= 7'd0;
      min_q   <= 7'd0;
      hour_q  <= 7'd0;
      ce_q    <= 1'b0;
      sck_q   <= 1'b0;
      io_q    <= 1'b0;
      io_oe_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ctrl.start) begin
            sec_q   <= ctrl.sec_bcd[6:0];
            min_q   <= ctrl.min_bcd[6:0];
            hour_q  <= ctrl.hour_bcd[6:0];
            frame_q <= FirstFrame;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b1;
            ce_q    <= 1'b1;
            io_oe_q <= 1'b1;
            io_q    <= start_word[0];
            state_q <= StCeSetup;
          end
        end
        StCeSetup: begin
          if (cnt_q == TceLast) begin
            cnt_q   <= 8'd0;
            bit_q   <= 4'd0;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StShift: begin
          if (cnt_q == DivLast) begin
            cnt_q <= 8'd0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              // Falling edge: advance to the next bit, or finish with bit 15 still on IO.
              sck_q <= 1'b0;
              if (bit_q == 4'd15) begin
                state_q <= StCeHold;
              end else begin
                bit_q <= bit_nxt;
                io_q  <= cur_word[bit_nxt];
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StCeHold: begin
          if (cnt_q == TceLast) begin
            cnt_q   <= 8'd0;
            ce_q    <= 1'b0;
            io_oe_q <= 1'b0;
            state_q <= StGap;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StGap: begin
          if (cnt_q == TceLast) begin
            cnt_q <= 8'd0;
            if (frame_q == LastFrame) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              frame_q <= frame_q + 3'd1;
              ce_q    <= 1'b1;
              io_oe_q <= 1'b1;
              io_q    <= nxt_word[0];
              state_q <= StCeSetup;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign CE        = ce_q;
  assign SCK       = sck_q;
  assign IO        = io_oe_q ? io_q : 1'bz;
  assign ctrl.busy = busy_q;
  assign ctrl.done = done_q;

endmodule

// File: tb/tb_rtc_write_ctrl.sv
// Bench for rtc_write_ctrl: serial frames captured on SCK rise are checked against a scoreboard.
// Two instances: defaults (CLK_DIV=4, T_CE=4) and the fast corner (CLK_DIV=2, T_CE=1).
module tb_rtc_write_ctrl;

`ifdef RTC_WP_SEQ_EN
  localparam int NFrames    = 5;
  localparam int SecFrameNo = 1;
`else
  localparam int NFrames    = 3;
  localparam int SecFrameNo = 0;
`endif

  typedef struct {
    logic [7:0] sec_in;
    logic [7:0] min_in;
    logic [7:0] hour_in;
    logic [7:0] sec_exp;
    logic [7:0] min_exp;
    logic [7:0] hour_exp;
  } vec_t;

  logic clk;
  logic rst_n;
  wire  ce0, sck0, io0;
  wire  ce1, sck1, io1;

  // Released IO reads back as 1; a driven 0 while CE=0 stands out.
  pullup (io0);
  pullup (io1);

  rtc_write_ctrl_if bus0 ();
  rtc_write_ctrl_if bus1 ();

  rtc_write_ctrl dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus0),
    .CE   (ce0),
    .SCK  (sck0),
    .IO   (io0)
  );

  rtc_write_ctrl #(
    .CLK_DIV(2),
    .T_CE   (1)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus1),
    .CE   (ce1),
    .SCK  (sck1),
    .IO   (io1)
  );

  int          nchecks;
  int          nfail;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic        prev_ce[2];
  logic        prev_sck[2];
  logic [15:0] bits[2];
  int          nbits[2];
  int          ce_len[2];
  int          hi_len[2];
  int          gap_len[2];
  int          frames_seen[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int tce_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int frame_len(input int d);
    return 3 * tce_of(d) + 32 * div_of(d);
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic done_of(input int d);
    return (d == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic ce_of(input int d);
    return (d == 0) ? ce0 : ce1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic [7:0] s, input logic [7:0] m,
                       input logic [7:0] h);
    if (d == 0) begin
      bus0.start = st; bus0.sec_bcd = s; bus0.min_bcd = m; bus0.hour_bcd = h;
    end else begin
      bus1.start = st; bus1.sec_bcd = s; bus1.min_bcd = m; bus1.hour_bcd = h;
    end
  endtask

  task automatic push_exp(input int d, input logic [15:0] w);
    if (d == 0) exp_q0.push_back(w);
    else exp_q1.push_back(w);
  endtask

  task automatic push_seq(input int d, input logic [7:0] es, input logic [7:0] em,
                          input logic [7:0] eh);
`ifdef RTC_WP_SEQ_EN
    push_exp(d, 16'h008E);
`endif
    push_exp(d, {es, 8'h80});
    push_exp(d, {em, 8'h82});
    push_exp(d, {eh, 8'h84});
`ifdef RTC_WP_SEQ_EN
    push_exp(d, 16'h808E);
`endif
  endtask

  task automatic mon_reset();
    for (int d = 0; d < 2; d++) begin
      prev_ce[d] = 1'b0; prev_sck[d] = 1'b0; bits[d] = '0; nbits[d] = 0;
      ce_len[d] = 0; hi_len[d] = 0; gap_len[d] = 0;
    end
  endtask

  task automatic frame_end(input int d);
    logic [15:0] e;
    int          sz;
    sz = (d == 0) ? exp_q0.size() : exp_q1.size();
    check($sformatf("dut%0d frame_expected", d), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      if (d == 0) e = exp_q0.pop_front();
      else e = exp_q1.pop_front();
      check($sformatf("dut%0d frame_word", d), 32'(bits[d]), 32'(e));
    end
  endtask

  task automatic monitor();
    logic  ce_s[2], sck_s[2], io_s[2], busy_s[2], done_s[2];
    string p;
    ce_s[0] = ce0;         ce_s[1] = ce1;
    sck_s[0] = sck0;       sck_s[1] = sck1;
    io_s[0] = io0;         io_s[1] = io1;
    busy_s[0] = bus0.busy; busy_s[1] = bus1.busy;
    done_s[0] = bus0.done; done_s[1] = bus1.done;
    for (int d = 0; d < 2; d++) begin
      p = $sformatf("dut%0d ", d);
      if (!ce_s[d]) begin
        check({p, "io_released"}, 32'(io_s[d]), 32'd1);
        check({p, "sck_idle"}, 32'(sck_s[d]), 32'd0);
        if (busy_s[d]) gap_len[d]++;
      end
      if (ce_s[d] && !prev_ce[d]) begin
        if (gap_len[d] != 0) check({p, "ce_gap_len"}, gap_len[d], tce_of(d));
        gap_len[d] = 0; ce_len[d] = 0; nbits[d] = 0; bits[d] = '0;
      end
      if (ce_s[d]) ce_len[d]++;
      if (sck_s[d] && !prev_sck[d]) begin
        bits[d] = {io_s[d], bits[d][15:1]};
        nbits[d]++;
      end
      if (sck_s[d]) begin
        hi_len[d]++;
      end else if (prev_sck[d]) begin
        check({p, "sck_high_len"}, hi_len[d], div_of(d));
        hi_len[d] = 0;
      end
      if (!ce_s[d] && prev_ce[d]) begin
        check({p, "ce_high_len"}, ce_len[d], 2 * tce_of(d) + 32 * div_of(d));
        check({p, "bits_per_frame"}, nbits[d], 16);
        frame_end(d);
        frames_seen[d]++;
      end
      if (done_s[d]) begin
        check({p, "last_gap_len"}, gap_len[d], tce_of(d));
        gap_len[d] = 0;
      end
      prev_ce[d] = ce_s[d];
      prev_sck[d] = sck_s[d];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  // One full sequence on instance d; optionally re-pulses start and changes inputs mid frame 2.
  task automatic run_seq(input int d, input logic [7:0] s, input logic [7:0] m,
                         input logic [7:0] h, input logic [7:0] es, input logic [7:0] em,
                         input logic [7:0] eh, input bit disturb);
    int f;
    int n;
    bit seen;
    int left;
    f = frame_len(d);
    seen = 1'b0;
    push_seq(d, es, em, eh);
    drive(d, 1'b1, s, m, h);
    tick();
    n = 1;
    check($sformatf("dut%0d busy_after_start", d), 32'(busy_of(d)), 32'd1);
    drive(d, 1'b0, s, m, h);
    while (!seen && n < NFrames * f + 20) begin
      if (disturb && n == 2 * f + f / 2) drive(d, 1'b1, 8'h11, 8'h22, 8'h08);
      else if (disturb && n == 2 * f + f / 2 + 1) drive(d, 1'b0, 8'h11, 8'h22, 8'h08);
      tick();
      n++;
      if (done_of(d)) seen = 1'b1;
      else check($sformatf("dut%0d busy_during_seq", d), 32'(busy_of(d)), 32'd1);
    end
    check($sformatf("dut%0d done_seen", d), 32'(seen), 32'd1);
    check($sformatf("dut%0d done_cycle", d), n, NFrames * f + 1);
    check($sformatf("dut%0d busy_in_done", d), 32'(busy_of(d)), 32'd0);
    left = (d == 0) ? exp_q0.size() : exp_q1.size();
    check($sformatf("dut%0d frames_outstanding", d), left, 0);
    // A start presented during the DONE cycle must be dropped.
    drive(d, 1'b1, 8'h01, 8'h02, 8'h03);
    tick();
    check($sformatf("dut%0d done_one_cycle", d), 32'(done_of(d)), 32'd0);
    check($sformatf("dut%0d start_in_done_busy", d), 32'(busy_of(d)), 32'd0);
    drive(d, 1'b0, 8'h01, 8'h02, 8'h03);
    tick();
    check($sformatf("dut%0d idle_busy", d), 32'(busy_of(d)), 32'd0);
    check($sformatf("dut%0d idle_ce", d), 32'(ce_of(d)), 32'd0);
    tick();
  endtask

  initial begin
    vec_t vecs[5];
    int   n;
    int   base;

    nchecks = 0;
    nfail = 0;
    frames_seen[0] = 0;
    frames_seen[1] = 0;
    vecs[0] = '{8'h45, 8'h30, 8'h12, 8'h45, 8'h30, 8'h12};
    vecs[1] = '{8'hD9, 8'h30, 8'h93, 8'h59, 8'h30, 8'h13};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 8'h23};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h7F};

    rst_n = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00, 8'h00);
    mon_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset ce", 32'(ce0), 32'd0);
    check("reset sck", 32'(sck0), 32'd0);
    check("reset io_released", 32'(io0), 32'd1);
    check("reset busy", 32'(bus0.busy), 32'd0);
    check("reset done", 32'(bus0.done), 32'd0);
    check("reset dut1 ce", 32'(ce1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 5; i++) begin
      run_seq(0, vecs[i].sec_in, vecs[i].min_in, vecs[i].hour_in,
              vecs[i].sec_exp, vecs[i].min_exp, vecs[i].hour_exp, 1'b0);
    end

    // Re-start and input changes while busy: only the latched values go out.
    run_seq(0, 8'h45, 8'h30, 8'h12, 8'h45, 8'h30, 8'h12, 1'b1);

    // Reset in the middle of the seconds frame shift.
    base = frames_seen[0];
    push_seq(0, 8'h45, 8'h30, 8'h12);
    drive(0, 1'b1, 8'h45, 8'h30, 8'h12);
    tick();
    drive(0, 1'b0, 8'h45, 8'h30, 8'h12);
    n = 0;
    while (!(frames_seen[0] == base + SecFrameNo && nbits[0] >= 4 && nbits[0] < 16) &&
           n < 1000) begin
      tick();
      n++;
    end
    check("abort reached_sec_shift", 32'(n < 1000), 32'd1);
    check("abort ce_before_reset", 32'(ce0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort ce", 32'(ce0), 32'd0);
    check("abort sck", 32'(sck0), 32'd0);
    check("abort io_released", 32'(io0), 32'd1);
    check("abort busy", 32'(bus0.busy), 32'd0);
    exp_q0.delete();
    mon_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("abort busy_after_release", 32'(bus0.busy), 32'd0);
    run_seq(0, 8'h07, 8'h08, 8'h09, 8'h07, 8'h08, 8'h09, 1'b0);

    // Fast corner: CLK_DIV=2, T_CE=1 gives 67-cycle frames and a 1-cycle CE gap.
    run_seq(1, 8'h45, 8'h30, 8'h12, 8'h45, 8'h30, 8'h12, 1'b0);
    run_seq(1, 8'hD9, 8'hA5, 8'h93, 8'h59, 8'h25, 8'h13, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
